prim_and_arbiter: RTL

- Shares one WIDTH-bit bitwise AND unit between N_REQ requesters.
- The AND unit is built only from gate-level `and` primitive instances, one per bit.
- Arbitration is round-robin. Operands are latched on grant, and the result is returned on a valid/ready response channel tagged with the requester index.
- Sits between gate-primitive exercisers and a shared primitive datapath; sequences every use of that datapath.

---
 rtl/prim_and_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/prim_and_arbiter.sv
// prim_and_arbiter: shares one WIDTH-bit AND unit, built from `and` gate primitives,
// between N_REQ requesters.
// Round-robin arbitration; the winner's operands are latched on grant and the result is
// returned on a valid/ready channel tagged with the winner's index.
// Optional build macro: PRIM_AND_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module prim_and_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_y,
    output logic [ID_W-1:0]        rsp_id
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StResp
    } state_t;

    state_t           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [N_REQ-1:0] gnt_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [ID_W-1:0]  rsp_id_q;

    logic [WIDTH-1:0] a_slice [N_REQ];
    logic [WIDTH-1:0] b_slice [N_REQ];
    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  ptr_next;
    wire  [WIDTH-1:0] and_y;

    // Unpack the flattened operand buses into per-requester slices.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign a_slice[g] = op_a[g*WIDTH +: WIDTH];
        assign b_slice[g] = op_b[g*WIDTH +: WIDTH];
    end

    // Shared datapath: one gate primitive per bit, fed only from the latched operands.
    for (genvar g = 0; g < WIDTH; g++) begin : g_and
        and u_and_bit (and_y[g], op_a_q[g], op_b_q[g]);
    end

    // Winner search: first set req bit starting at ptr_q and wrapping around.
    always_comb begin
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Pointer advance; fixed priority pins it at zero so the search always starts at bit 0.
    always_comb begin
`ifdef PRIM_AND_ARB_FIXED_PRIO_EN
        ptr_next = '0;
`else
        ptr_next = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
    end

    // Arbiter FSM with registered grant and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    gnt_q <= '0;
                    if (win_found) begin
                        gnt_q   <= N_REQ'(1) << win_idx;
                        op_a_q  <= a_slice[win_idx];
                        op_b_q  <= b_slice[win_idx];
                        id_q    <= win_idx;
                        ptr_q   <= ptr_next;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    gnt_q       <= '0;
                    rsp_y_q     <= and_y;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    // Result and id stay put after the handshake; only valid drops.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

`ifndef SYNTHESIS
    // Grant is at most one-hot and never overlaps a pending response.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_rsp_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                      !((|gnt) && rsp_valid));
`endif

endmodule
